// File: rtl/alu_arbiter_pkg.sv
// Shared ALU function codes for the arbiter and anything driving the external ALU.
// Codes follow the MIPS R-type funct field; FUN_NO marks "no operation".
package alu_arbiter_pkg;

  localparam logic [5:0] FUN_SLL  = 6'h00;
  localparam logic [5:0] FUN_SRL  = 6'h02;
  localparam logic [5:0] FUN_SRA  = 6'h03;
  localparam logic [5:0] FUN_JR   = 6'h08;
  localparam logic [5:0] FUN_JALR = 6'h09;
  localparam logic [5:0] FUN_ADD  = 6'h20;
  localparam logic [5:0] FUN_ADDU = 6'h21;
  localparam logic [5:0] FUN_SUB  = 6'h22;
  localparam logic [5:0] FUN_SUBU = 6'h23;
  localparam logic [5:0] FUN_AND  = 6'h24;
  localparam logic [5:0] FUN_OR   = 6'h25;
  localparam logic [5:0] FUN_XOR  = 6'h26;
  localparam logic [5:0] FUN_NOR  = 6'h27;
  localparam logic [5:0] FUN_SLT  = 6'h2a;
  localparam logic [5:0] FUN_SLTU = 6'h2b;
  localparam logic [5:0] FUN_NO   = 6'h3f;

  // Jumps and no-ops produce no arithmetic result; the arbiter substitutes zero.
  function automatic logic funct_bypasses_alu(input logic [5:0] f);
    return (f == FUN_JR) || (f == FUN_JALR) || (f == FUN_NO);
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// Combinational round-robin grant: first asserted request at or above ptr, wrapping.
// Implemented by rotating requests down by ptr, isolating the lowest bit, rotating back.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  logic [NUM_REQ-1:0]   w_rot_gnt;
  logic [2*NUM_REQ-1:0] w_back;

  always_comb begin
    w_dbl     = {req, req} >> ptr;
    w_rot     = w_dbl[NUM_REQ-1:0];
    w_rot_gnt = w_rot & (~w_rot + NUM_REQ'(1));
    w_back    = {w_rot_gnt, w_rot_gnt} << ptr;
    grant     = w_back[2*NUM_REQ-1:NUM_REQ];
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU among NUM_REQ requesters.
// One operation in flight: accept (IDLE) -> drive ALU (EXEC) -> hold result (RESP).
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     reqValid,
  output logic [NUM_REQ-1:0]     reqReady,
  input  logic [32*NUM_REQ-1:0]  reqOpA,
  input  logic [32*NUM_REQ-1:0]  reqOpB,
  input  logic [6*NUM_REQ-1:0]   reqFunct,
  output logic [NUM_REQ-1:0]     respValid,
  input  logic [NUM_REQ-1:0]     respReady,
  output logic [31:0]            respOut,
  output logic                   respZero,
  output logic [31:0]            aluOpA,
  output logic [31:0]            aluOpB,
  output logic [5:0]             aluFunct,
  input  logic [31:0]            aluOut,
  input  logic                   aluZero
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   r_gnt;
  logic [31:0]        r_opA;
  logic [31:0]        r_opB;
  logic [5:0]         r_funct;
  logic [31:0]        r_resp_out;
  logic               r_resp_zero;

  logic [NUM_REQ-1:0] w_grant;
  logic [PTR_W-1:0]   w_gnt_idx;
  logic [31:0]        w_opA;
  logic [31:0]        w_opB;
  logic [5:0]         w_funct;
  logic [NUM_REQ-1:0] w_resp_onehot;
  logic [PTR_W-1:0]   w_ptr_next;
  logic               w_accept;
  logic               w_release;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .req   (reqValid),
    .ptr   (r_ptr),
    .grant (w_grant)
  );

  // Encode the one-hot grant and pick the granted requester's operands.
  always_comb begin
    w_gnt_idx = '0;
    w_opA     = '0;
    w_opB     = '0;
    w_funct   = FUN_NO;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_gnt_idx = PTR_W'(i);
        w_opA     = reqOpA[32*i +: 32];
        w_opB     = reqOpB[32*i +: 32];
        w_funct   = reqFunct[6*i +: 6];
      end
    end
  end

  assign w_resp_onehot = NUM_REQ'(1) << r_gnt;
  assign w_ptr_next    = (r_gnt == PTR_W'(NUM_REQ - 1)) ? '0 : r_gnt + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    reqReady  = '0;
    respValid = '0;
    aluOpA    = '0;
    aluOpB    = '0;
    aluFunct  = FUN_NO;
    w_accept  = 1'b0;
    w_release = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!reset && (|reqValid)) begin
          reqReady = w_grant;
          w_accept = 1'b1;
          w_next   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        aluOpA   = r_opA;
        aluOpB   = r_opB;
        aluFunct = r_funct;
        w_next   = ST_RESP;
      end
      ST_RESP: begin
        if (!reset) respValid = w_resp_onehot;
        if (|(respReady & w_resp_onehot)) begin
          w_release = 1'b1;
          w_next    = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Stage boundary: request latch (IDLE), result capture (EXEC), pointer advance (RESP).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr       <= '0;
      r_gnt       <= '0;
      r_opA       <= '0;
      r_opB       <= '0;
      r_funct     <= '0;
      r_resp_out  <= '0;
      r_resp_zero <= 1'b0;
    end else begin
      if (w_accept) begin
        r_opA   <= w_opA;
        r_opB   <= w_opB;
        r_funct <= w_funct;
        r_gnt   <= w_gnt_idx;
      end
      if (r_state == ST_EXEC) begin
        if (funct_bypasses_alu(r_funct)) begin
          r_resp_out  <= '0;
          r_resp_zero <= 1'b1;
        end else begin
          r_resp_out  <= aluOut;
          r_resp_zero <= aluZero;
        end
      end
      if (w_release) r_ptr <= w_ptr_next;
    end
  end

  assign respOut  = r_resp_out;
  assign respZero = r_resp_zero;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter with three requesters: directed scenarios then random traffic,
// checked against a transaction-level model of grant order and results.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int NR  = 3;
  localparam int NFL = 11;

  logic            clk = 1'b0;
  logic            reset;
  logic [NR-1:0]   reqValid, reqReady, respValid, respReady;
  logic [32*NR-1:0] reqOpA, reqOpB;
  logic [6*NR-1:0] reqFunct;
  logic [31:0]     respOut, aluOpA, aluOpB, aluOut;
  logic            respZero, aluZero;
  logic [5:0]      aluFunct;

  int checks = 0;
  int errors = 0;
  int mptr   = 0;
  logic [31:0] mA [NR];
  logic [31:0] mB [NR];
  logic [5:0]  mF [NR];
  logic [5:0]  fl [NFL] = '{FUN_ADD, FUN_SUB, FUN_AND, FUN_OR, FUN_XOR, FUN_NOR,
                            FUN_SLT, FUN_SLTU, FUN_JR, FUN_JALR, FUN_NO};

  alu_arbiter #(.NUM_REQ(NR)) dut (
    .clk(clk), .reset(reset), .reqValid(reqValid), .reqReady(reqReady),
    .reqOpA(reqOpA), .reqOpB(reqOpB), .reqFunct(reqFunct),
    .respValid(respValid), .respReady(respReady), .respOut(respOut), .respZero(respZero),
    .aluOpA(aluOpA), .aluOpB(aluOpB), .aluFunct(aluFunct), .aluOut(aluOut), .aluZero(aluZero)
  );

  always #5 clk = ~clk;

  // External ALU; non-arithmetic codes yield garbage the arbiter must not forward.
  function automatic logic [31:0] alu_fn(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      FUN_ADD:  return a + b;
      FUN_SUB:  return a - b;
      FUN_AND:  return a & b;
      FUN_OR:   return a | b;
      FUN_XOR:  return a ^ b;
      FUN_NOR:  return ~(a | b);
      FUN_SLT:  return {31'b0, $signed(a) < $signed(b)};
      FUN_SLTU: return {31'b0, a < b};
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  always_comb begin
    aluOut  = alu_fn(aluFunct, aluOpA, aluOpB);
    aluZero = (aluOut == 32'd0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [NR-1:0] m, input int p);
    for (int k = 0; k < NR; k++) begin
      if (((m >> ((p + k) % NR)) & NR'(1)) != '0) return (p + k) % NR;
    end
    return -1;
  endfunction

  task automatic drive_ops();
    for (int i = 0; i < NR; i++) begin
      reqOpA[32*i +: 32] = mA[i];
      reqOpB[32*i +: 32] = mB[i];
      reqFunct[6*i +: 6] = mF[i];
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NR; i++) begin
      mA[i] = $urandom;
      mB[i] = ($urandom_range(0, 3) == 0) ? mA[i] : $urandom;
      mF[i] = fl[$urandom_range(0, NFL - 1)];
    end
  endtask

  // Called at a falling edge with the DUT idle; returns at a falling edge with it idle again.
  task automatic txn(input logic [NR-1:0] mask, input int bp);
    int g;
    logic [31:0] ea, eb, er;
    logic [5:0]  ef;
    logic        ez, byp;
    drive_ops();
    reqValid  = mask;
    respReady = '0;
    g = pick(mask, mptr);
    #1;
    chk("idle_funct", 32'(aluFunct), 32'(FUN_NO));
    if (g < 0) begin
      chk("no_grant", 32'(reqReady), 32'd0);
      @(negedge clk);
      return;
    end
    chk("grant", 32'(reqReady), 32'(1) << g);
    ea = mA[g]; eb = mB[g]; ef = mF[g];
    byp = (ef == FUN_JR) || (ef == FUN_JALR) || (ef == FUN_NO);
    er  = byp ? 32'd0 : alu_fn(ef, ea, eb);
    ez  = byp ? 1'b1 : (er == 32'd0);
    @(negedge clk);
    rand_ops();
    drive_ops();
    reqValid = mask | NR'($urandom);
    #1;
    chk("exec_ready", 32'(reqReady), 32'd0);
    chk("exec_valid", 32'(respValid), 32'd0);
    chk("exec_opA", aluOpA, ea);
    chk("exec_opB", aluOpB, eb);
    chk("exec_funct", 32'(aluFunct), 32'(ef));
    @(negedge clk);
    #1;
    for (int k = 0; k <= bp; k++) begin
      chk("resp_valid", 32'(respValid), 32'(1) << g);
      chk("resp_out", respOut, er);
      chk("resp_zero", 32'(respZero), 32'(ez));
      chk("resp_ready", 32'(reqReady), 32'd0);
      chk("resp_funct", 32'(aluFunct), 32'(FUN_NO));
      if (k < bp) begin
        respReady = NR'($urandom) & ~(NR'(1) << g);
        @(negedge clk);
        #1;
      end
    end
    respReady = (NR'(1) << g) | NR'($urandom);
    @(negedge clk);
    respReady = '0;
    mptr = (g + 1) % NR;
    #1;
    chk("done_valid", 32'(respValid), 32'd0);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    reqValid  = '1;
    respReady = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_ready", 32'(reqReady), 32'd0);
    chk("rst_valid", 32'(respValid), 32'd0);
    chk("rst_out", respOut, 32'd0);
    chk("rst_zero", 32'(respZero), 32'd0);
    chk("rst_funct", 32'(aluFunct), 32'(FUN_NO));
    chk("rst_opA", aluOpA, 32'd0);
    reset    = 1'b0;
    reqValid = '0;
    mptr     = 0;
  endtask

  initial begin
    reset = 1'b1; reqValid = '0; respReady = '0;
    reqOpA = '0; reqOpB = '0; reqFunct = '0;
    for (int i = 0; i < NR; i++) begin mA[i] = 0; mB[i] = 0; mF[i] = FUN_NO; end
    do_reset();

    // Single request on line 0: 5 + 7.
    mA[0] = 32'd5; mB[0] = 32'd7; mF[0] = FUN_ADD;
    txn(3'b001, 0);

    // Contention from reset: line 0 SUB 3,3 then line 1 OR F0,0F.
    do_reset();
    mA[0] = 32'd3;    mB[0] = 32'd3;    mF[0] = FUN_SUB;
    mA[1] = 32'hF0;   mB[1] = 32'h0F;   mF[1] = FUN_OR;
    txn(3'b011, 0);
    mA[1] = 32'hF0;   mB[1] = 32'h0F;   mF[1] = FUN_OR;
    txn(3'b011, 0);

    // Back-pressure for four cycles.
    mA[0] = 32'h1111_0000; mB[0] = 32'h0000_2222; mF[0] = FUN_XOR;
    txn(3'b001, 4);

    // Jump code bypasses the ALU result.
    mA[1] = 32'h1234; mB[1] = 32'd0; mF[1] = FUN_JR;
    txn(3'b010, 1);

    // Reset while line 1 holds a response.
    do_reset();
    mA[0] = 32'd1; mB[0] = 32'd2; mF[0] = FUN_ADD;
    txn(3'b011, 0);
    mA[1] = 32'd9; mB[1] = 32'd4; mF[1] = FUN_SUB;
    drive_ops();
    reqValid = 3'b011;
    #1;
    chk("rr_grant1", 32'(reqReady), 32'd2);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("pre_rst_valid", 32'(respValid), 32'd2);
    chk("pre_rst_out", respOut, 32'd5);
    reset = 1'b1;
    #1;
    chk("in_rst_valid", 32'(respValid), 32'd0);
    chk("in_rst_ready", 32'(reqReady), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    reqValid = '0;
    mptr = 0;
    #1;
    chk("post_rst_valid", 32'(respValid), 32'd0);
    chk("post_rst_out", respOut, 32'd0);
    rand_ops();
    txn(3'b011, 0);

    // All lines valid continuously: grants rotate.
    for (int n = 0; n < 2 * NR; n++) begin
      rand_ops();
      txn('1, 0);
    end

    // Random traffic.
    for (int n = 0; n < 60; n++) begin
      rand_ops();
      txn(NR'($urandom), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
